wb_regfile: RTL and testbench

//  Write-back stage and general-purpose register file. Consumes MEM/WB latch outputs:
//  reg_write_reg, mem_to_reg_reg, alu_result_reg, data_load_reg, dst_reg.

---
 rtl/wb_regfile_pkg.sv | 8 +
 rtl/regfile_2r1w.sv | 37 +++
 rtl/wb_regfile.sv | 49 ++++
 tb/tb_wb_regfile.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants used by the write-back stage, the MEM/WB latch and
// the decode/forwarding logic.
package wb_regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NREGS    = 2**ADDR_W;
   localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_2r1w.sv
// General-purpose register array: one synchronous write port, two combinational
// read ports, synchronous clear, register 0 hardwired to zero.
module regfile_2r1w
   import wb_regfile_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b
);
   localparam int NR = 2**AW;

   logic [DW-1:0] regs [NR];

   // Entry 0 has no storage, so every read of index 0 is zero by construction.
   assign regs[REG_ZERO] = '0;

   for (genvar i = 1; i < NR; i++) begin : g_reg
      always_ff @(posedge clk) begin
         if (rst)
            regs[i] <= '0;
         else if (we && waddr == AW'(i))
            regs[i] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, qualifies the write, commits it
// to the register file and bypasses it onto both decode read ports.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = wb_regfile_pkg::DATA_W,
   parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] data_load,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_dst,
   output logic [DATA_W-1:0] wb_data
);
   logic [DATA_W-1:0] rf_rs, rf_rt;

   assign wb_data = mem_to_reg ? data_load : alu_result;
   assign wb_dst  = dst;
   // Dropping dst==0 here keeps the bypass from ever exposing a nonzero r0.
   assign wb_we   = reg_write && (dst != ADDR_W'(REG_ZERO)) && !rst;

   regfile_2r1w #(
      .DW (DATA_W),
      .AW (ADDR_W)
   ) u_rf (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_we),
      .waddr   (dst),
      .wdata   (wb_data),
      .raddr_a (rs_addr),
      .raddr_b (rt_addr),
      .rdata_a (rf_rs),
      .rdata_b (rf_rt)
   );

   // Write-first: a read of the register being written sees the new value.
   assign rs_data = (wb_we && rs_addr == dst) ? wb_data : rf_rs;
   assign rt_data = (wb_we && rt_addr == dst) ? wb_data : rf_rt;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write paths, bypass, r0 and reset mid-op.
module tb_wb_regfile;
   logic        clk = 1'b0;
   logic        rst;
   logic        reg_write;
   logic        mem_to_reg;
   logic [31:0] alu_result;
   logic [31:0] data_load;
   logic [4:0]  dst;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        wb_we;
   logic [4:0]  wb_dst;
   logic [31:0] wb_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .reg_write  (reg_write),
      .mem_to_reg (mem_to_reg),
      .alu_result (alu_result),
      .data_load  (data_load),
      .dst        (dst),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .wb_we      (wb_we),
      .wb_dst     (wb_dst),
      .wb_data    (wb_data)
   );

   // Advance past one rising edge; inputs are then changed 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_result = '0;
      data_load  = '0;
      dst        = '0;
   endtask

   task automatic wr(input logic [4:0] d, input logic [31:0] v);
      reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = v; dst = d;
      tick();
      idle();
   endtask

   task automatic test_reset();
      int bad;
      for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
      rs_addr = 5'd1; rt_addr = 5'd31; #1;
      tests++;
      if (rs_data !== 32'hA5A5_0001 || rt_data !== 32'hA5A5_001F) begin
         fails++;
         $display("FAIL preload: rs=%h rt=%h, required A5A50001 A5A5001F", rs_data, rt_data);
      end
      // A write presented during reset must be lost and wb_we forced low.
      rst = 1'b1; reg_write = 1'b1; alu_result = 32'h0000_0077; dst = 5'd4; #1;
      tests++;
      if (wb_we !== 1'b0 || wb_dst !== 5'd4 || wb_data !== 32'h77) begin
         fails++;
         $display("FAIL reset_we: wb_we=%b dst=%0d data=%h, required 0 4 00000077", wb_we, wb_dst, wb_data);
      end
      tick();
      rst = 1'b0; idle();
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i); rt_addr = 5'(31 - i); #1;
         if (rs_data !== 32'h0 || rt_data !== 32'h0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset_clear: %0d nonzero reads, required 0", bad);
      end
   endtask

   task automatic test_alu_write();
      reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'h1234; data_load = 32'hDEAD;
      dst = 5'd5; rs_addr = 5'd1; #1;
      tests++;
      if (wb_data !== 32'h1234 || wb_we !== 1'b1) begin
         fails++;
         $display("FAIL alu_mux: wb_data=%h wb_we=%b, required 00001234 1", wb_data, wb_we);
      end
      tick();
      rs_addr = 5'd5; #1;
      tests++;
      if (rs_data !== 32'h1234) begin
         fails++;
         $display("FAIL alu_write: rs=%h, required 00001234", rs_data);
      end
   endtask

   task automatic test_load_write();
      reg_write = 1'b1; mem_to_reg = 1'b1; alu_result = 32'h1111; data_load = 32'hBEEF;
      dst = 5'd6; rt_addr = 5'd2; #1;
      tests++;
      if (wb_data !== 32'hBEEF) begin
         fails++;
         $display("FAIL load_mux: wb_data=%h, required 0000BEEF", wb_data);
      end
      tick();
      rt_addr = 5'd6; rs_addr = 5'd5; #1;
      tests++;
      if (rt_data !== 32'hBEEF || rs_data !== 32'h1234) begin
         fails++;
         $display("FAIL load_write: rt=%h rs=%h, required 0000BEEF 00001234", rt_data, rs_data);
      end
   endtask

   task automatic test_bypass();
      wr(5'd7, 32'h0000_1111);
      rs_addr = 5'd7; rt_addr = 5'd7;
      reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'hCAFE; dst = 5'd7; #1;
      tests++;
      if (rs_data !== 32'hCAFE || rt_data !== 32'hCAFE) begin
         fails++;
         $display("FAIL bypass_same: rs=%h rt=%h, required 0000CAFE 0000CAFE", rs_data, rt_data);
      end
      tick();
      idle(); #1;
      tests++;
      if (rs_data !== 32'hCAFE || rt_data !== 32'hCAFE) begin
         fails++;
         $display("FAIL bypass_commit: rs=%h rt=%h, required 0000CAFE 0000CAFE", rs_data, rt_data);
      end
      // Only the port addressing the destination may be bypassed.
      rs_addr = 5'd7; rt_addr = 5'd6;
      reg_write = 1'b1; alu_result = 32'h7777; dst = 5'd7; #1;
      tests++;
      if (rs_data !== 32'h7777 || rt_data !== 32'hBEEF) begin
         fails++;
         $display("FAIL bypass_split: rs=%h rt=%h, required 00007777 0000BEEF", rs_data, rt_data);
      end
      tick();
      idle();
   endtask

   task automatic test_zero_reg();
      rs_addr = 5'd0; rt_addr = 5'd0;
      reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'hFFFF_FFFF; dst = 5'd0; #1;
      tests++;
      if (wb_we !== 1'b0 || rs_data !== 32'h0 || rt_data !== 32'h0 || wb_data !== 32'hFFFF_FFFF) begin
         fails++;
         $display("FAIL zero_pre: wb_we=%b rs=%h rt=%h wb_data=%h, required 0 0 0 FFFFFFFF",
                  wb_we, rs_data, rt_data, wb_data);
      end
      tick();
      idle(); #1;
      tests++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
         fails++;
         $display("FAIL zero_post: rs=%h rt=%h, required 0 0", rs_data, rt_data);
      end
   endtask

   task automatic test_disabled_write();
      wr(5'd9, 32'h99);
      rs_addr = 5'd9; rt_addr = 5'd9;
      reg_write = 1'b0; mem_to_reg = 1'b0; alu_result = 32'h55; dst = 5'd9; #1;
      tests++;
      if (wb_we !== 1'b0 || rs_data !== 32'h99 || rt_data !== 32'h99) begin
         fails++;
         $display("FAIL disabled_pre: wb_we=%b rs=%h rt=%h, required 0 00000099 00000099",
                  wb_we, rs_data, rt_data);
      end
      tick(); #1;
      tests++;
      if (rs_data !== 32'h99) begin
         fails++;
         $display("FAIL disabled_post: rs=%h, required 00000099", rs_data);
      end
      idle();
   endtask

   task automatic test_reset_mid_op();
      wr(5'd3, 32'h0000_3030);
      rs_addr = 5'd3; rt_addr = 5'd3;
      rst = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'h33; dst = 5'd3; #1;
      tests++;
      if (wb_we !== 1'b0 || rs_data !== 32'h3030) begin
         fails++;
         $display("FAIL midrst_pre: wb_we=%b rs=%h, required 0 00003030", wb_we, rs_data);
      end
      tick();
      rst = 1'b0; reg_write = 1'b0; #1;
      tests++;
      if (rs_data !== 32'h0) begin
         fails++;
         $display("FAIL midrst_clear: rs=%h, required 00000000", rs_data);
      end
      reg_write = 1'b1; alu_result = 32'h44; #1;
      tests++;
      if (wb_we !== 1'b1 || rt_data !== 32'h44) begin
         fails++;
         $display("FAIL midrst_bypass: wb_we=%b rt=%h, required 1 00000044", wb_we, rt_data);
      end
      tick();
      idle(); #1;
      tests++;
      if (rs_data !== 32'h44 || rt_data !== 32'h44) begin
         fails++;
         $display("FAIL midrst_commit: rs=%h rt=%h, required 00000044 00000044", rs_data, rt_data);
      end
   endtask

   initial begin
      rst = 1'b0; rs_addr = '0; rt_addr = '0;
      idle();
      #1;
      test_reset();
      test_alu_write();
      test_load_write();
      test_bypass();
      test_zero_reg();
      test_disabled_write();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
